// File: rtl/ms_timer_pkg.sv
// Shared types and defaults for the millisecond timer.
// Holds the countdown FSM state encoding and the default prescaler length.
package ms_timer_pkg;

    localparam int DEFAULT_CLKS_PER_MS = 50000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk down to one wrap event every CLKS_PER_MS advancing cycles.
// A clear restarts the count from zero and suppresses any wrap in that cycle.
module ms_prescaler #(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    input  logic clear,
    output logic wrap
);

    localparam int PW = $clog2(CLKS_PER_MS);

    logic [PW-1:0] count;

    assign wrap = advance && !clear && (count == PW'(CLKS_PER_MS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + PW'(1);
        end
    end

endmodule

// File: rtl/ms_timer.sv
// Millisecond tick generator with a pausable, abortable ms countdown.
// The prescaler free-runs while enabled; a start realigns it to the countdown.
import ms_timer_pkg::*;

module ms_timer #(
    parameter int CLKS_PER_MS = DEFAULT_CLKS_PER_MS,
    parameter int MS_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            onems_tick,
    input  logic            start,
    input  logic [MS_W-1:0] load_ms,
    input  logic            pause,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [MS_W-1:0] remaining_ms
);

    state_t          state, state_next;
    logic [MS_W-1:0] remaining_next;
    logic            done_next;
    logic            advance;
    logic            clear;
    logic            wrap;

    assign busy = (state != IDLE);

    // A held pause freezes the prescaler even on the cycle RUN enters PAUSE,
    // so pause always beats a coincident wrap.
    assign advance = en && !(busy && pause);
    assign clear   = en && !abort && (state == IDLE) && start && (load_ms != '0);

    ms_prescaler #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .advance(advance),
        .clear  (clear),
        .wrap   (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            remaining_ms <= '0;
            done         <= 1'b0;
            onems_tick   <= 1'b0;
        end else begin
            state        <= state_next;
            remaining_ms <= remaining_next;
            done         <= done_next;
            onems_tick   <= wrap;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_next     = state;
        remaining_next = remaining_ms;
        done_next      = 1'b0;

        if (abort) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (load_ms != '0) begin
                            state_next     = RUN;
                            remaining_next = load_ms;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                RUN, PAUSE: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else begin
                        // Leaving PAUSE resumes immediately, so a wrap here counts.
                        state_next = RUN;
                        if (wrap && (remaining_ms != '0)) begin
                            remaining_next = remaining_ms - MS_W'(1);
                            if (remaining_ms == MS_W'(1)) begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_timer.sv
// Directed self-checking bench for ms_timer with CLKS_PER_MS=10, MS_W=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ms_timer;

    localparam int CLKS = 10;
    localparam int MW   = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          onems_tick;
    logic          start;
    logic [MW-1:0] load_ms;
    logic          pause;
    logic          abort;
    logic          busy;
    logic          done;
    logic [MW-1:0] remaining_ms;

    int checks = 0;
    int errors = 0;

    ms_timer #(
        .CLKS_PER_MS(CLKS),
        .MS_W       (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .onems_tick  (onems_tick),
        .start       (start),
        .load_ms     (load_ms),
        .pause       (pause),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .remaining_ms(remaining_ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        start   = 1'b0;
        load_ms = '0;
        pause   = 1'b0;
        abort   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_tick", onems_tick, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rem", remaining_ms, 0);

        // Free-run: tick after release edges 10, 20, ..., 100
        rst = 1'b1;
        en  = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            step();
            check($sformatf("free_tick_%0d", j), onems_tick, (j % 10 == 0));
            check($sformatf("free_idle_%0d", j), {busy, done}, 0);
        end

        // 3 ms countdown
        load_ms = 8'd3;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("cd3_busy0", busy, 1);
        check("cd3_rem0", remaining_ms, 3);
        for (int j = 1; j <= 30; j++) begin
            step();
            check($sformatf("cd3_rem_%0d", j), remaining_ms, 3 - j / 10);
            check($sformatf("cd3_tick_%0d", j), onems_tick, (j % 10 == 0));
            check($sformatf("cd3_done_%0d", j), done, (j == 30));
            check($sformatf("cd3_busy_%0d", j), busy, (j < 30));
        end
        step();
        check("cd3_after_busy", busy, 0);
        check("cd3_after_done", done, 0);

        // Zero-length start: immediate done, never busy
        load_ms = 8'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_rem", remaining_ms, 0);
        step();
        check("zero_done_clr", done, 0);
        check("zero_busy_after", busy, 0);

        // 2 ms countdown with pause held across edges +4..+8
        load_ms = 8'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            step();
            check($sformatf("pz_rem_%0d", j), remaining_ms, (j < 15) ? 2 : (j < 25) ? 1 : 0);
            check($sformatf("pz_tick_%0d", j), onems_tick, (j == 15 || j == 25));
            check($sformatf("pz_done_%0d", j), done, (j == 25));
            check($sformatf("pz_busy_%0d", j), busy, (j < 25));
            if (j == 3) pause = 1'b1;
            if (j == 8) pause = 1'b0;
        end

        // 5 ms countdown aborted at remaining_ms=2
        load_ms = 8'd5;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 30; j++) step();
        check("ab_rem_pre", remaining_ms, 2);
        check("ab_busy_pre", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_rem", remaining_ms, 0);
        check("ab_done", done, 0);
        for (int j = 1; j <= 40; j++) begin
            step();
            check($sformatf("ab_quiet_%0d", j), {busy, done}, 0);
        end

        // start and abort together in IDLE
        load_ms = 8'd4;
        start   = 1'b1;
        abort   = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_rem", remaining_ms, 0);
        check("sa_done", done, 0);
        step();
        check("sa_busy_after", busy, 0);

        // Reset mid-countdown at remaining_ms=3
        load_ms = 8'd5;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 20; j++) step();
        check("mr_rem_pre", remaining_ms, 3);
        rst = 1'b0;
        step();
        check("mr_tick", onems_tick, 0);
        check("mr_done", done, 0);
        check("mr_busy", busy, 0);
        check("mr_rem", remaining_ms, 0);
        rst = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            step();
            check($sformatf("mr_tick_%0d", j), onems_tick, (j % 10 == 0));
            check($sformatf("mr_quiet_%0d", j), {busy, done}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ms_timer.md
MS_TIMER -- requirements
Module: ms_timer

Interface
REQ-001 SHALL have parameter CLKS_PER_MS, default 50000, clk cycles per 1 ms tick (legal values >= 2).
REQ-002 SHALL have parameter MS_W, default 16, width of ms count fields.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  in  1  prescaler enable; when 0, prescaler and countdown are frozen.
REQ-006 SHALL have port onems_tick  out  1  one-cycle strobe, once per CLKS_PER_MS enabled cycles.
REQ-007 SHALL have port start  in  1  countdown start request.
REQ-008 SHALL have port load_ms  in  MS_W  countdown length in ms, sampled with start.
REQ-009 SHALL have port pause  in  1  level; freezes countdown and prescaler while in RUN.
REQ-010 SHALL have port abort  in  1  cancels countdown.
REQ-011 SHALL have port busy  out  1  high in RUN and PAUSE.
REQ-012 SHALL have port done  out  1  one-cycle pulse at countdown expiry.
REQ-013 SHALL have port remaining_ms  out  MS_W  ms left in the current countdown.

Function
REQ-014 Prescaler SHALL be a counter of width $clog2(CLKS_PER_MS) that advances only when en=1 and not frozen by PAUSE or by the pause-priority cycle in REQ-022; wrap event = counter at CLKS_PER_MS-1 while advancing; on wrap, counter <= 0.
REQ-015 onems_tick SHALL be registered, set to 1 on the edge that samples a wrap event and 0 otherwise; never high two consecutive cycles.
REQ-016 FSM SHALL have states IDLE, RUN, PAUSE.
REQ-017 IDLE + start=1 + abort=0 + load_ms!=0 SHALL: state <= RUN, remaining_ms <= load_ms, prescaler counter <= 0. The first wrap therefore occurs exactly CLKS_PER_MS enabled cycles later.
REQ-018 IDLE + start=1 + abort=0 + load_ms==0 SHALL pulse done for one cycle; state stays IDLE; busy stays 0.
REQ-019 RUN + wrap event SHALL decrement remaining_ms by 1 on the same edge that sets onems_tick.
REQ-020 RUN + wrap event with remaining_ms==1 SHALL set remaining_ms <= 0, done <= 1 (coincident with onems_tick), state <= IDLE.
REQ-021 N ms countdown SHALL make done high in the cycle after edge k+N*CLKS_PER_MS, where k = start-sampling edge, with en=1 throughout and no pause.
REQ-022 RUN + pause=1 SHALL go to PAUSE; the prescaler does not advance in that cycle (pause beats wrap); remaining_ms is held.
REQ-023 PAUSE + pause=0 SHALL return to RUN; the prescaler resumes from its held value. pause is ignored in IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 SHALL force state <= IDLE and remaining_ms <= 0 with no done pulse, from any state. It has priority over start, pause and wrap in the same cycle.
REQ-026 en=0 SHALL hold the prescaler, remaining_ms and state; abort still acts.
REQ-027 remaining_ms SHALL never underflow; the decrement is applied only when remaining_ms is nonzero.

Reset
REQ-028 rst=0 at a clk edge SHALL set: state IDLE, prescaler 0, onems_tick 0, done 0, busy 0, remaining_ms 0; this applies mid-countdown, and no done is emitted for the cancelled countdown.
REQ-029 After reset release with en=1, the first onems_tick SHALL occur CLKS_PER_MS cycles after the first non-reset edge.

Structure
REQ-030 Package ms_timer_pkg SHALL hold the state enum (IDLE, RUN, PAUSE) and the default CLKS_PER_MS constant.
REQ-031 The prescaler SHALL be sub-module ms_prescaler, with inputs clk, rst, advance and clear, and output wrap; the FSM and remaining_ms live in ms_timer.

Verification (CLKS_PER_MS=10, MS_W=8)
REQ-032 Reset, then en=1 free-run for 100 cycles -> onems_tick high exactly on cycles 10, 20, ..., 100 after release; busy=0, done=0.
REQ-033 start with load_ms=3 -> busy=1 next cycle; remaining_ms 3->2->1->0 at +10/+20/+30 edges; done and onems_tick high together at +30; busy=0 after.
REQ-034 start with load_ms=0 -> done high for one cycle at +1, busy never 1, remaining_ms stays 0.
REQ-035 load_ms=2 with pause held 5 cycles starting at +4 -> done at +25, no onems_tick during pause.
REQ-036 load_ms=5, abort at remaining_ms=2 -> busy=0, remaining_ms=0, no done; start+abort same cycle in IDLE -> stays IDLE, busy=0.
REQ-037 rst=0 mid-countdown (remaining_ms=3) -> all outputs 0 next cycle; no done after release.
